poly_encoder_framer: RTL



---
 rtl/enc_pkg.sv | 15 +
 rtl/coeff_scaler.sv | 16 +
 rtl/poly_encoder_framer.sv | 100 ++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared constants and state type for the polynomial encoder/decoder pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package enc_pkg;

   localparam int POLY_SIZE_D    = 16;
   localparam int OUTPUT_WIDTH_D = 16;
   localparam int SCALE_FACTOR_D = 2;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } enc_state_t;

endpackage

// File: rtl/coeff_scaler.sv
// Scales a binary data word into a coefficient by an exact left shift.
// Latency: combinational.
// Backpressure: none; pure datapath.
module coeff_scaler #(
   parameter int OUTPUT_WIDTH = 16,
   parameter int SCALE_FACTOR = 2
) (
   input  logic [OUTPUT_WIDTH-1:0]              in_data,
   output logic [OUTPUT_WIDTH+SCALE_FACTOR-1:0] coeff
);

   // Zero-extended shift: the result is wide enough that no data bit is lost,
   // so a downstream right shift by SCALE_FACTOR recovers the word exactly.
   assign coeff = {in_data, {SCALE_FACTOR{1'b0}}};

endmodule

// File: rtl/poly_encoder_framer.sv
// Packs POLY_SIZE scaled coefficients into one frame for the polynomial decoder.
// Latency: frame valid the cycle after the last word is accepted; POLY_SIZE+1 cycles/frame min.
// Backpressure: in_ready low while a frame is held; frame held until poly_ready.
// Optional: define ENC_PARTIAL_FLUSH_EN to add a flush input that zero-pads a partial frame.
module poly_encoder_framer
   import enc_pkg::*;
#(
   parameter int POLY_SIZE    = POLY_SIZE_D,
   parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_D,
   parameter int SCALE_FACTOR = SCALE_FACTOR_D,
   localparam int COEFF_W     = OUTPUT_WIDTH + SCALE_FACTOR
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [OUTPUT_WIDTH-1:0]       in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
`ifdef ENC_PARTIAL_FLUSH_EN
   input  logic                          flush,
`endif
   output logic [COEFF_W*POLY_SIZE-1:0]  poly_coeff,
   output logic                          poly_valid,
   input  logic                          poly_ready,
   output logic [15:0]                   frame_cnt
);

   localparam int IDX_W = (POLY_SIZE > 1) ? $clog2(POLY_SIZE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POLY_SIZE - 1);

   enc_state_t         state;
   logic [IDX_W-1:0]   idx;
   logic [COEFF_W-1:0] coeff;
   logic               accept;
   logic               flush_go;
   int                 fill_start;

   coeff_scaler #(
      .OUTPUT_WIDTH (OUTPUT_WIDTH),
      .SCALE_FACTOR (SCALE_FACTOR)
   ) u_scaler (
      .in_data (in_data),
      .coeff   (coeff)
   );

   // Ready is gated by reset so nothing is taken while the block is held in reset.
   assign in_ready = rst_n && (state == FILL);
   assign accept   = in_valid && in_ready;

   // Partial-frame flush: pad from the first slot not written this cycle.
   always_comb begin
      flush_go   = 1'b0;
      fill_start = int'(idx) + (accept ? 1 : 0);
`ifdef ENC_PARTIAL_FLUSH_EN
      flush_go   = flush && in_ready && ((idx != '0) || accept);
`endif
   end

   // Framer FSM: fill slots in order, then hold the complete frame until handoff.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= FILL;
         idx        <= '0;
         poly_coeff <= '0;
         poly_valid <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         case (state)
            FILL: begin
               // Unwritten slots keep old contents; they are never exposed
               // because the frame is only presented once every slot is fresh.
               for (int k = 0; k < POLY_SIZE; k++) begin
                  if (accept && (k == int'(idx)))
                     poly_coeff[k*COEFF_W +: COEFF_W] <= coeff;
                  else if (flush_go && (k >= fill_start))
                     poly_coeff[k*COEFF_W +: COEFF_W] <= '0;
               end
               if ((accept && (idx == LAST_IDX)) || flush_go) begin
                  idx        <= '0;
                  state      <= HOLD;
                  poly_valid <= 1'b1;
               end else if (accept) begin
                  idx <= idx + 1'b1;
               end
            end
            HOLD: begin
               if (poly_ready) begin
                  state      <= FILL;
                  poly_valid <= 1'b0;
                  frame_cnt  <= frame_cnt + 16'd1;
               end
            end
            default: begin
               state      <= FILL;
               poly_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
